timer_csr: RTL and testbench

- Register/control front-end for the timer block. Sits between the CPU-side register bus and the timer.
- Drives the timer's start, enable, period and counter_rst inputs from programmable registers.
- Samples the timer's interrupt and counter outputs, turning the interrupt level into a sticky, maskable CPU interrupt.
- Generates the slow-rate tick (clock-enable) the timer advances on. Everything runs on one clock.

---
 rtl/timer_pkg.sv | 29 ++
 rtl/timer_prescaler.sv | 42 ++++
 rtl/timer_csr.sv | 195 +++++++++++++++++++
 tb/tb_timer_csr.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer register front-end: register word
// addresses, CTRL/STATUS bit positions and the bus FSM state encoding.
package timer_pkg;

    // Register word addresses
    localparam int unsigned REG_CTRL     = 0;
    localparam int unsigned REG_PERIOD   = 1;
    localparam int unsigned REG_COUNT    = 2;
    localparam int unsigned REG_STATUS   = 3;
    localparam int unsigned REG_PRESCALE = 4;

    // CTRL register bit positions
    localparam int unsigned CTRL_START   = 2;
    localparam int unsigned CTRL_ENABLE  = 3;
    localparam int unsigned CTRL_IRQ_EN  = 4;
    localparam int unsigned CTRL_IRQ     = 5;
    localparam int unsigned CTRL_CNT_RST = 7;

    // STATUS register bit positions
    localparam int unsigned STAT_PENDING = 0;
    localparam int unsigned STAT_OVERRUN = 1;

    // Bus handshake FSM: accept in IDLE, answer in RESP
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } bus_state_e;

endpackage : timer_pkg

// File: rtl/timer_prescaler.sv
// Programmable clock-enable generator. The counter runs 0..presc and
// emits a one-cycle tick when it reaches presc, then wraps. A clear
// request zeroes the counter and suppresses the tick in that cycle;
// while run is low the counter is parked at zero.
module timer_prescaler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic         clear,
    input  logic [W-1:0] presc,
    output logic         tick
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count and tick: park/clear first, then compare-and-wrap
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!run || clear) begin
            cnt_d = '0;
        end else if (cnt_q == presc) begin
            tick  = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : timer_prescaler

// File: rtl/timer_csr.sv
// Register front-end for the timer. Decodes single-beat CPU register
// accesses, holds the timer control registers, turns the timer's
// interrupt level into a sticky maskable interrupt with overrun
// tracking, and produces the prescaled tick the timer advances on.
module timer_csr
    import timer_pkg::*;
#(
    parameter int              ADDR_W    = 3,
    parameter int              DATA_W    = 16,
    parameter logic [DATA_W-1:0] PRESC_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              tmr_start,
    output logic              tmr_enable,
    output logic              tmr_counter_rst,
    output logic [DATA_W-1:0] tmr_period,
    input  logic              tmr_interrupt,
    input  logic [DATA_W-1:0] tmr_counter,
    output logic              tick,
    output logic              irq
);

    bus_state_e        state_q, state_d;
    logic              start_q, start_d;
    logic              enable_q, enable_d;
    logic              irq_en_q, irq_en_d;
    logic [DATA_W-1:0] period_q, period_d;
    logic [DATA_W-1:0] presc_q, presc_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic              int_q, int_d;
    logic              cnt_rst_q, cnt_rst_d;
    logic              presc_wr_q, presc_wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              accept;
    logic              pend_clr;
    logic              ovr_clr;
    logic              int_rise;
    logic              presc_clear;

    // Bus handshake, register decode, writes and read-data capture
    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        enable_d   = enable_q;
        irq_en_d   = irq_en_q;
        period_d   = period_q;
        presc_d    = presc_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        cnt_rst_d  = 1'b0;
        presc_wr_d = 1'b0;
        pend_clr   = 1'b0;
        ovr_clr    = 1'b0;
        accept     = (state_q == ST_IDLE) && req_valid;

        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            rdata_d = '0;
            err_d   = 1'b0;
            case (req_addr)
                ADDR_W'(REG_CTRL): begin
                    rdata_d[CTRL_START]  = start_q;
                    rdata_d[CTRL_ENABLE] = enable_q;
                    rdata_d[CTRL_IRQ_EN] = irq_en_q;
                    rdata_d[CTRL_IRQ]    = pending_q;
                    if (req_write) begin
                        start_d   = req_wdata[CTRL_START];
                        enable_d  = req_wdata[CTRL_ENABLE];
                        irq_en_d  = req_wdata[CTRL_IRQ_EN];
                        pend_clr  = req_wdata[CTRL_IRQ];
                        cnt_rst_d = req_wdata[CTRL_CNT_RST];
                    end
                end
                ADDR_W'(REG_PERIOD): begin
                    rdata_d = period_q;
                    if (req_write) period_d = req_wdata;
                end
                ADDR_W'(REG_COUNT): begin
                    rdata_d = tmr_counter;
                end
                ADDR_W'(REG_STATUS): begin
                    rdata_d[STAT_PENDING] = pending_q;
                    rdata_d[STAT_OVERRUN] = overrun_q;
                    if (req_write) begin
                        pend_clr = req_wdata[STAT_PENDING];
                        ovr_clr  = req_wdata[STAT_OVERRUN];
                    end
                end
                ADDR_W'(REG_PRESCALE): begin
                    rdata_d = presc_q;
                    if (req_write) begin
                        presc_d    = req_wdata;
                        presc_wr_d = 1'b1;
                    end
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
            if (req_write) rdata_d = '0;
        end
    end

    // Interrupt edge capture: a rising edge beats a same-cycle clear,
    // and only counts as an overrun if pending survives the clear
    always_comb begin
        int_d     = tmr_interrupt;
        int_rise  = tmr_interrupt && !int_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (pend_clr) pending_d = 1'b0;
        if (ovr_clr)  overrun_d = 1'b0;
        if (int_rise) begin
            if (pending_q && !pend_clr) overrun_d = 1'b1;
            pending_d = 1'b1;
        end
    end

    // State, register and strobe flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            period_q   <= '0;
            presc_q    <= PRESC_RST;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            int_q      <= 1'b0;
            cnt_rst_q  <= 1'b0;
            presc_wr_q <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            period_q   <= period_d;
            presc_q    <= presc_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            int_q      <= int_d;
            cnt_rst_q  <= cnt_rst_d;
            presc_wr_q <= presc_wr_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Writing PRESCALE or pulsing the timer counter reset restarts the
    // prescale count in the same cycle the new settings appear
    assign presc_clear = presc_wr_q || cnt_rst_q;

    timer_prescaler #(
        .W(DATA_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (start_q),
        .clear(presc_clear),
        .presc(presc_q),
        .tick (tick)
    );

    // Output mapping; response fields are only driven during RESP
    assign req_ready       = (state_q == ST_IDLE);
    assign rsp_valid       = (state_q == ST_RESP);
    assign rsp_rdata       = (state_q == ST_RESP) ? rdata_q : '0;
    assign rsp_err         = (state_q == ST_RESP) && err_q;
    assign tmr_start       = start_q;
    assign tmr_enable      = enable_q;
    assign tmr_counter_rst = cnt_rst_q;
    assign tmr_period      = period_q;
    assign irq             = pending_q && irq_en_q;

endmodule : timer_csr

// File: tb/tb_timer_csr.sv
// Self-checking bench for timer_csr with a register-level reference model.
module tb_timer_csr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        tmr_start;
    logic        tmr_enable;
    logic        tmr_counter_rst;
    logic [15:0] tmr_period;
    logic        tmr_interrupt = 1'b0;
    logic [15:0] tmr_counter = '0;
    logic        tick;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int crst_count = 0;
    int crst_cyc = -1;

    // Reference model state
    logic        m_start, m_enable, m_irqen, m_pending, m_overrun;
    logic [15:0] m_period, m_presc;
    int          m_zero;

    // Snapshot of outputs taken in the response cycle
    logic [15:0] snap_period;
    logic        snap_start, snap_enable, snap_irq;

    timer_csr #(.ADDR_W(3), .DATA_W(16), .PRESC_RST(16'd0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .tmr_start(tmr_start), .tmr_enable(tmr_enable),
        .tmr_counter_rst(tmr_counter_rst), .tmr_period(tmr_period),
        .tmr_interrupt(tmr_interrupt), .tmr_counter(tmr_counter),
        .tick(tick), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tmr_counter_rst) begin
            crst_count <= crst_count + 1;
            crst_cyc   <= cyc;
        end
    end

    task automatic model_reset();
        m_start = 0; m_enable = 0; m_irqen = 0; m_pending = 0; m_overrun = 0;
        m_period = '0; m_presc = '0; m_zero = 0;
    endtask

    function automatic logic [15:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return 16'(m_start) * 16'd4 + 16'(m_enable) * 16'd8
                       + 16'(m_irqen) * 16'd16 + 16'(m_pending) * 16'd32;
            3'd1: return m_period;
            3'd2: return tmr_counter;
            3'd3: return 16'(m_overrun) * 16'd2 + 16'(m_pending);
            3'd4: return m_presc;
            default: return 16'd0;
        endcase
    endfunction

    // rc is the response cycle, when the write becomes visible
    task automatic model_write(input logic [2:0] a, input logic [15:0] wd, input int rc);
        case (a)
            3'd0: begin
                if (wd[7]) m_zero = rc + 1;
                else if (!m_start && wd[2]) m_zero = rc;
                m_start = wd[2]; m_enable = wd[3]; m_irqen = wd[4];
                if (wd[5]) m_pending = 0;
            end
            3'd1: m_period = wd;
            3'd3: begin
                if (wd[0]) m_pending = 0;
                if (wd[1]) m_overrun = 0;
            end
            3'd4: begin m_presc = wd; m_zero = rc + 1; end
            default: ;
        endcase
    endtask

    task automatic model_rise();
        if (m_pending) m_overrun = 1;
        m_pending = 1;
    endtask

    function automatic logic model_tick(input int c);
        if (!m_start || c < m_zero) return 1'b0;
        return ((c - m_zero) % (int'(m_presc) + 1)) == int'(m_presc);
    endfunction

    // One bus access; starts and ends one time unit after a rising edge
    task automatic bus(input logic wr, input logic [2:0] a, input logic [15:0] wd,
                       output logic [15:0] rd, output logic er, output logic ok, output int rc);
        req_valid = 1; req_write = wr; req_addr = a; req_wdata = wd;
        ok = req_ready;
        @(posedge clk); #1;
        req_valid = 0; req_write = 0;
        rc = cyc;
        ok = ok & rsp_valid & ~req_ready;
        rd = rsp_rdata; er = rsp_err;
        snap_period = tmr_period; snap_start = tmr_start;
        snap_enable = tmr_enable; snap_irq = irq;
        @(posedge clk); #1;
        ok = ok & ~rsp_valid & req_ready;
    endtask

    task automatic pulse_int();
        tmr_interrupt = 1; @(posedge clk); #1;
        tmr_interrupt = 0; @(posedge clk); #1;
        model_rise();
    endtask

    task automatic test_reset();
        logic [15:0] rd; logic er, ok; int rc;
        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, tmr_start, tmr_enable, tmr_counter_rst,
             tmr_period, tick, irq} !== {1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("[TB] FAIL reset_outputs: ready=%b valid=%b err=%b rdata=%h start=%b en=%b crst=%b period=%h tick=%b irq=%b, expected ready=1 and all others 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata, tmr_start, tmr_enable, tmr_counter_rst, tmr_period, tick, irq);
        end
        rst = 1;
        @(posedge clk); #1;
        model_reset();
        tmr_counter = 16'h5A5A;
        for (int a = 0; a < 8; a++) begin
            bus(0, 3'(a), 16'd0, rd, er, ok, rc);
            n_checks++;
            if (rd !== model_read(3'(a)) || er !== (a >= 5) || ok !== 1'b1) begin
                n_errors++;
                $display("[TB] FAIL reset_read addr %0d: got rdata=%h err=%b handshake_ok=%b, expected rdata=%h err=%b handshake_ok=1",
                         a, rd, er, ok, model_read(3'(a)), (a >= 5));
            end
        end
    endtask

    task automatic test_regs();
        logic [15:0] rd, wd; logic er, ok, wr; logic [2:0] a; int rc;
        bus(1, 3'd1, 16'h0010, rd, er, ok, rc); model_write(3'd1, 16'h0010, rc);
        bus(1, 3'd0, 16'h000C, rd, er, ok, rc); model_write(3'd0, 16'h000C, rc);
        n_checks++;
        if (snap_period !== 16'h0010 || snap_start !== 1'b1 || snap_enable !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL ctrl_outputs: period=%h start=%b enable=%b, expected 0010 1 1",
                     snap_period, snap_start, snap_enable);
        end
        crst_count = 0;
        bus(1, 3'd0, 16'h0084, rd, er, ok, rc); model_write(3'd0, 16'h0084, rc);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (crst_count !== 1 || crst_cyc !== rc) begin
            n_errors++;
            $display("[TB] FAIL counter_rst_pulse: %0d pulses, last in cycle %0d, expected 1 pulse in cycle %0d",
                     crst_count, crst_cyc, rc);
        end
        bus(0, 3'd0, 16'd0, rd, er, ok, rc);
        n_checks++;
        if (rd !== 16'h0004) begin
            n_errors++;
            $display("[TB] FAIL ctrl_after_crst: got %h expected 0004", rd);
        end
        for (int i = 0; i < 24; i++) begin
            a = 3'($urandom_range(0, 7));
            wr = 1'($urandom_range(0, 1));
            wd = 16'($urandom);
            tmr_counter = 16'($urandom);
            bus(wr, a, wd, rd, er, ok, rc);
            if (wr) begin
                model_write(a, wd, rc);
                n_checks++;
                if (rd !== 16'd0 || er !== (a >= 3'd5) || ok !== 1'b1 || snap_period !== m_period
                    || snap_start !== m_start || snap_enable !== m_enable || snap_irq !== (m_pending & m_irqen)) begin
                    n_errors++;
                    $display("[TB] FAIL rand_write addr %0d data %h: rdata=%h err=%b ok=%b period=%h start=%b en=%b irq=%b, expected 0000 %b 1 %h %b %b %b",
                             a, wd, rd, er, ok, snap_period, snap_start, snap_enable, snap_irq,
                             (a >= 3'd5), m_period, m_start, m_enable, m_pending & m_irqen);
                end
            end else begin
                n_checks++;
                if (rd !== model_read(a) || er !== (a >= 3'd5) || ok !== 1'b1) begin
                    n_errors++;
                    $display("[TB] FAIL rand_read addr %0d: rdata=%h err=%b ok=%b, expected %h %b 1",
                             a, rd, er, ok, model_read(a), (a >= 3'd5));
                end
            end
        end
        bus(1, 3'd0, 16'h0000, rd, er, ok, rc); model_write(3'd0, 16'h0000, rc);
    endtask

    task automatic watch_ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (tick !== model_tick(cyc)) begin
                n_errors++;
                $display("[TB] FAIL tick_%s cycle %0d (prescale %0d): got %b expected %b",
                         tag, cyc, m_presc, tick, model_tick(cyc));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_prescaler();
        logic [15:0] rd, p; logic er, ok; int rc;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? 16'd3 : 16'($urandom_range(0, 6));
            bus(1, 3'd4, p, rd, er, ok, rc); model_write(3'd4, p, rc);
            bus(1, 3'd0, 16'h0004, rd, er, ok, rc); model_write(3'd0, 16'h0004, rc);
            watch_ticks(3 * (int'(p) + 1) + 2, "run");
            if (k == 0) begin
                bus(1, 3'd4, 16'd1, rd, er, ok, rc); model_write(3'd4, 16'd1, rc);
                watch_ticks(9, "rewrite");
                crst_count = 0;
                bus(1, 3'd0, 16'h0084, rd, er, ok, rc); model_write(3'd0, 16'h0084, rc);
                watch_ticks(7, "cnt_rst");
            end
            bus(1, 3'd0, 16'h0000, rd, er, ok, rc); model_write(3'd0, 16'h0000, rc);
            watch_ticks(4, "stopped");
        end
        crst_count = 0;
        bus(1, 3'd0, 16'h0084, rd, er, ok, rc); model_write(3'd0, 16'h0084, rc);
        n_checks++;
        if (snap_start !== 1'b1 || crst_count !== 1 || crst_cyc !== rc) begin
            n_errors++;
            $display("[TB] FAIL start_with_crst: start=%b pulses=%0d cycle=%0d, expected 1 1 %0d",
                     snap_start, crst_count, crst_cyc, rc);
        end
        watch_ticks(8, "start_crst");
        bus(1, 3'd0, 16'h0000, rd, er, ok, rc); model_write(3'd0, 16'h0000, rc);
    endtask

    task automatic test_interrupt();
        logic [15:0] rd, wd; logic er, ok; int rc, op;
        bus(1, 3'd0, 16'h0010, rd, er, ok, rc); model_write(3'd0, 16'h0010, rc);
        tmr_interrupt = 1; @(posedge clk); #1;
        model_rise();
        n_checks++;
        if (irq !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL irq_latency: irq=%b one cycle after edge, expected 1", irq);
        end
        @(posedge clk); #1; tmr_interrupt = 0;
        @(posedge clk); #1;
        pulse_int();
        bus(0, 3'd3, 16'd0, rd, er, ok, rc);
        n_checks++;
        if (rd !== 16'h0003) begin
            n_errors++;
            $display("[TB] FAIL status_overrun: got %h expected 0003", rd);
        end
        bus(0, 3'd0, 16'd0, rd, er, ok, rc);
        n_checks++;
        if (rd !== 16'h0030) begin
            n_errors++;
            $display("[TB] FAIL ctrl_pending: got %h expected 0030", rd);
        end
        bus(1, 3'd3, 16'h0003, rd, er, ok, rc); model_write(3'd3, 16'h0003, rc);
        n_checks++;
        if (snap_irq !== 1'b0 || irq !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL irq_cleared: irq=%b (response cycle %b), expected 0", irq, snap_irq);
        end
        for (int i = 0; i < 16; i++) begin
            op = $urandom_range(0, 2);
            if (op == 0) begin
                pulse_int();
            end else if (op == 1) begin
                wd = 16'($urandom_range(0, 3));
                bus(1, 3'd3, wd, rd, er, ok, rc); model_write(3'd3, wd, rc);
            end else begin
                wd = 16'h0010 | (16'($urandom_range(0, 1)) << 5);
                bus(1, 3'd0, wd, rd, er, ok, rc); model_write(3'd0, wd, rc);
            end
            bus(0, 3'd3, 16'd0, rd, er, ok, rc);
            n_checks++;
            if (rd !== model_read(3'd3) || irq !== (m_pending & m_irqen)) begin
                n_errors++;
                $display("[TB] FAIL rand_irq step %0d op %0d: status=%h irq=%b, expected %h %b",
                         i, op, rd, irq, model_read(3'd3), m_pending & m_irqen);
            end
        end
    endtask

    task automatic test_w1c_race();
        logic [15:0] rd; logic er, ok; int rc;
        bus(1, 3'd3, 16'h0003, rd, er, ok, rc); model_write(3'd3, 16'h0003, rc);
        pulse_int();
        tmr_interrupt = 1;
        bus(1, 3'd3, 16'h0001, rd, er, ok, rc);
        tmr_interrupt = 0;
        model_write(3'd3, 16'h0001, rc);
        model_rise();
        m_overrun = 0;
        bus(0, 3'd3, 16'd0, rd, er, ok, rc);
        n_checks++;
        if (rd !== 16'h0001 || rd !== model_read(3'd3)) begin
            n_errors++;
            $display("[TB] FAIL w1c_race: status=%h expected 0001", rd);
        end
        n_checks++;
        if (snap_irq !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL w1c_race_irq: irq=%b expected 1", snap_irq);
        end
    endtask

    task automatic test_back_to_back();
        req_valid = 1; req_write = 0; req_addr = 3'd1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 5) req_valid = 0;
            n_checks++;
            if (rsp_valid !== (i % 2 == 0) || req_ready !== (i % 2 != 0)
                || (rsp_valid && rsp_rdata !== m_period)) begin
                n_errors++;
                $display("[TB] FAIL back_to_back step %0d: valid=%b ready=%b rdata=%h, expected %b %b %h",
                         i, rsp_valid, req_ready, rsp_rdata, (i % 2 == 0), (i % 2 != 0), m_period);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd; logic er, ok; int rc;
        bus(1, 3'd1, 16'h1234, rd, er, ok, rc); model_write(3'd1, 16'h1234, rc);
        bus(1, 3'd4, 16'h0005, rd, er, ok, rc); model_write(3'd4, 16'h0005, rc);
        bus(1, 3'd0, 16'h001C, rd, er, ok, rc); model_write(3'd0, 16'h001C, rc);
        req_valid = 1; req_write = 0; req_addr = 3'd1;
        @(posedge clk); #1;
        req_valid = 0;
        rst = 0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || tmr_start !== 1'b0 || tmr_period !== 16'd0) begin
            n_errors++;
            $display("[TB] FAIL reset_mid: valid=%b ready=%b start=%b period=%h, expected 0 1 0 0000",
                     rsp_valid, req_ready, tmr_start, tmr_period);
        end
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || tick !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL reset_release: valid=%b ready=%b tick=%b, expected 0 1 0",
                     rsp_valid, req_ready, tick);
        end
        model_reset();
        for (int a = 0; a < 5; a++) begin
            bus(0, 3'(a), 16'd0, rd, er, ok, rc);
            n_checks++;
            if (rd !== model_read(3'(a)) || er !== 1'b0 || ok !== 1'b1) begin
                n_errors++;
                $display("[TB] FAIL post_reset_read addr %0d: rdata=%h err=%b ok=%b, expected %h 0 1",
                         a, rd, er, ok, model_read(3'(a)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_prescaler();
        test_interrupt();
        test_w1c_race();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_timer_csr
